// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: register-file geometry defaults,
// writeback source encodings and a saturating-increment helper.
package wb_pkg;

  localparam int NREG = 8;
  localparam int DW   = 16;

  typedef enum logic [1:0] {
    REGSRC_MEM  = 2'b00,
    REGSRC_ALU  = 2'b01,
    REGSRC_SPEC = 2'b10,
    REGSRC_PC   = 2'b11
  } regsrc_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) begin
      return val;
    end else begin
      return val + 32'd1;
    end
  endfunction

endpackage : wb_pkg

// File: rtl/wb_regfile_rf_bank.sv
// Architectural register storage: one synchronous write port, two raw
// asynchronous read ports, asynchronous active-low clear of every entry.
module rf_bank #(
  parameter int NREG = 8,
  parameter int DW   = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] regs_q [NREG];

  // Storage update: cleared on reset, single entry written when enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule : rf_bank

// File: rtl/wb_regfile.sv
// Writeback stage: source select, register file with write-to-read bypass,
// sticky halt, and an optional retired-instruction counter (WB_RETIRE_CNT_EN).
module wb_regfile #(
  parameter int NREG = 8,
  parameter int DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DW-1:0]           MW_readMemData,
  input  logic [DW-1:0]           MW_aluOut,
  input  logic [DW-1:0]           MW_specOps,
  input  logic [DW-1:0]           MW_pc_inc,
  input  logic [1:0]              MW_regSrc,
  input  logic                    MW_regWrite,
  input  logic [$clog2(NREG)-1:0] MW_writeReg,
  input  logic                    MW_valid,
  input  logic                    MW_halt,
  input  logic [$clog2(NREG)-1:0] rd_addr1,
  input  logic [$clog2(NREG)-1:0] rd_addr2,
  output logic [DW-1:0]           rd_data1,
  output logic [DW-1:0]           rd_data2,
  output logic [DW-1:0]           wb_data,
  output logic                    wb_en,
  output logic                    halted,
  output logic [31:0]             retire_cnt
);

  import wb_pkg::*;

  localparam int AW = $clog2(NREG);

  logic [DW-1:0] wb_data_s;
  logic          wb_en_s;
  logic [DW-1:0] raw1_s;
  logic [DW-1:0] raw2_s;
  logic [DW-1:0] rd_data1_s;
  logic [DW-1:0] rd_data2_s;
  logic          halted_q;
  logic          halted_d;

  // Writeback source select
  always_comb begin
    wb_data_s = MW_readMemData;
    case (regsrc_e'(MW_regSrc))
      REGSRC_MEM:  wb_data_s = MW_readMemData;
      REGSRC_ALU:  wb_data_s = MW_aluOut;
      REGSRC_SPEC: wb_data_s = MW_specOps;
      REGSRC_PC:   wb_data_s = MW_pc_inc;
      default:     wb_data_s = MW_readMemData;
    endcase
  end

  // Gating with rst_n keeps the write enable (and hence the bypass) dead while in reset
  assign wb_en_s = rst_n & MW_valid & MW_regWrite & ~halted_q;

  rf_bank #(
    .NREG (NREG),
    .DW   (DW),
    .AW   (AW)
  ) u_rf_bank (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .we_i     (wb_en_s),
    .waddr_i  (MW_writeReg),
    .wdata_i  (wb_data_s),
    .raddr1_i (rd_addr1),
    .raddr2_i (rd_addr2),
    .rdata1_o (raw1_s),
    .rdata2_o (raw2_s)
  );

  // Read port 1 with write-to-read bypass
  always_comb begin
    if (wb_en_s && (rd_addr1 == MW_writeReg)) begin
      rd_data1_s = wb_data_s;
    end else begin
      rd_data1_s = raw1_s;
    end
  end

  // Read port 2 with write-to-read bypass
  always_comb begin
    if (wb_en_s && (rd_addr2 == MW_writeReg)) begin
      rd_data2_s = wb_data_s;
    end else begin
      rd_data2_s = raw2_s;
    end
  end

  // Halt is sticky: once set only reset clears it
  always_comb begin
    if (MW_valid && MW_halt) begin
      halted_d = 1'b1;
    end else begin
      halted_d = halted_q;
    end
  end

  // Halt flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_q;
  logic [31:0] retire_d;

  // Count valid instructions, HALT included, until halted
  always_comb begin
    if (MW_valid && !halted_q) begin
      retire_d = sat_inc32(retire_q);
    end else begin
      retire_d = retire_q;
    end
  end

  // Retired-instruction counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= 32'h0000_0000;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = 32'h0000_0000;
`endif

  assign rd_data1 = rd_data1_s;
  assign rd_data2 = rd_data2_s;
  assign wb_data  = wb_data_s;
  assign wb_en    = wb_en_s;
  assign halted   = halted_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: random stimulus against an array-based
// reference model of the register file, halt flag and retire counter.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_d, alu_d, spec_d, pc_d;
  logic [1:0]  src;
  logic        rw, vld, hlt;
  logic [2:0]  wreg, ra1, ra2;
  logic [15:0] rd_data1, rd_data2, wb_data;
  logic        wb_en, halted;
  logic [31:0] retire_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0]     m_regs [8];
  bit              m_halted;
  longint unsigned m_cnt;

`ifdef WB_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MW_readMemData (mem_d),
    .MW_aluOut      (alu_d),
    .MW_specOps     (spec_d),
    .MW_pc_inc      (pc_d),
    .MW_regSrc      (src),
    .MW_regWrite    (rw),
    .MW_writeReg    (wreg),
    .MW_valid       (vld),
    .MW_halt        (hlt),
    .rd_addr1       (ra1),
    .rd_addr2       (ra2),
    .rd_data1       (rd_data1),
    .rd_data2       (rd_data2),
    .wb_data        (wb_data),
    .wb_en          (wb_en),
    .halted         (halted),
    .retire_cnt     (retire_cnt)
  );

  function automatic logic [15:0] exp_wb();
    case (src)
      2'b00:   return mem_d;
      2'b01:   return alu_d;
      2'b10:   return spec_d;
      default: return pc_d;
    endcase
  endfunction

  function automatic bit exp_wen();
    return rst_n && vld && rw && !m_halted;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (exp_wen() && a == wreg) return exp_wb();
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_cnt();
    return CNT_EN ? 32'(m_cnt) : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_halted = 1'b0;
    m_cnt = 0;
  endtask

  task automatic tick();
    bit w, c, h;
    logic [15:0] v;
    logic [2:0] a;
    w = exp_wen();
    v = exp_wb();
    a = wreg;
    c = rst_n && vld && !m_halted;
    h = rst_n && vld && hlt && !m_halted;
    @(posedge clk);
    #1;
    if (w) m_regs[a] = v;
    if (h) m_halted = 1'b1;
    if (c && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
  endtask

  task automatic rand_inputs();
    mem_d = 16'($urandom); alu_d = 16'($urandom);
    spec_d = 16'($urandom); pc_d = 16'($urandom);
    src = 2'($urandom); rw = 1'($urandom); vld = 1'($urandom);
    wreg = 3'($urandom); ra1 = 3'($urandom); ra2 = 3'($urandom);
    hlt = 1'b0;
  endtask

  task automatic set_bubble();
    vld = 1'b0; rw = 1'b0; hlt = 1'b0;
  endtask

  task automatic test_reset();
    rand_inputs();
    vld = 1'b1; rw = 1'b1; src = 2'b01;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (wb_en !== 1'b0) begin failures++; $display("FAIL reset_wb_en got=%b exp=0", wb_en); end
    checks++;
    if (wb_data !== alu_d) begin failures++; $display("FAIL reset_wb_data got=%h exp=%h", wb_data, alu_d); end
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i);
      #1;
      checks++;
      if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
        failures++; $display("FAIL reset_read addr=%0d got=%h/%h exp=0000/0000", i, rd_data1, rd_data2);
      end
    end
    checks++;
    if (halted !== 1'b0 || retire_cnt !== 32'h0) begin
      failures++; $display("FAIL reset_state halted=%b cnt=%h exp=0/0", halted, retire_cnt);
    end
    set_bubble();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_bypass();
    rand_inputs();
    vld = 1'b1; rw = 1'b1; src = 2'b01; alu_d = 16'h1234; wreg = 3'd3; ra1 = 3'd3;
    @(negedge clk);
    checks++;
    if (rd_data1 !== 16'h1234 || wb_en !== 1'b1) begin
      failures++; $display("FAIL bypass_same_cycle got=%h en=%b exp=1234 en=1", rd_data1, wb_en);
    end
    tick();
    set_bubble();
    @(negedge clk);
    checks++;
    if (rd_data1 !== 16'h1234) begin failures++; $display("FAIL bypass_storage got=%h exp=1234", rd_data1); end
    tick();
  endtask

  task automatic test_sources();
    logic [1:0]  s_tab [3] = '{2'b00, 2'b10, 2'b11};
    logic [2:0]  r_tab [3] = '{3'd0, 3'd1, 3'd7};
    logic [15:0] v_tab [3] = '{16'hAAAA, 16'h5555, 16'h0042};
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      vld = 1'b1; rw = 1'b1; src = s_tab[i]; wreg = r_tab[i];
      case (i)
        0: mem_d = v_tab[i];
        1: spec_d = v_tab[i];
        default: pc_d = v_tab[i];
      endcase
      @(negedge clk);
      checks++;
      if (wb_data !== v_tab[i]) begin failures++; $display("FAIL src_select src=%b got=%h exp=%h", s_tab[i], wb_data, v_tab[i]); end
      tick();
    end
    set_bubble();
    for (int i = 0; i < 3; i++) begin
      ra1 = r_tab[i];
      #1;
      checks++;
      if (rd_data1 !== v_tab[i]) begin failures++; $display("FAIL src_store r%0d got=%h exp=%h", r_tab[i], rd_data1, v_tab[i]); end
    end
    tick();
  endtask

  task automatic test_bubble();
    logic [15:0] old;
    logic [31:0] cnt0;
    old = m_regs[2];
    cnt0 = exp_cnt();
    rand_inputs();
    vld = 1'b0; rw = 1'b1; wreg = 3'd2; src = 2'b01; alu_d = 16'hFFFF; ra2 = 3'd2;
    @(negedge clk);
    checks++;
    if (wb_en !== 1'b0 || rd_data2 !== old) begin
      failures++; $display("FAIL bubble_comb en=%b rd=%h exp en=0 rd=%h", wb_en, rd_data2, old);
    end
    tick();
    set_bubble();
    @(negedge clk);
    checks++;
    if (rd_data2 !== old || retire_cnt !== cnt0) begin
      failures++; $display("FAIL bubble_state rd=%h cnt=%h exp rd=%h cnt=%h", rd_data2, retire_cnt, old, cnt0);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      rand_inputs();
      @(negedge clk);
      checks++;
      if (rd_data1 !== exp_rd(ra1) || rd_data2 !== exp_rd(ra2) || wb_data !== exp_wb() || wb_en !== exp_wen()) begin
        failures++;
        $display("FAIL random_cycle n=%0d got rd=%h/%h wb=%h en=%b exp rd=%h/%h wb=%h en=%b",
                 n, rd_data1, rd_data2, wb_data, wb_en, exp_rd(ra1), exp_rd(ra2), exp_wb(), exp_wen());
      end
      tick();
      checks++;
      if (retire_cnt !== exp_cnt()) begin failures++; $display("FAIL random_count got=%h exp=%h", retire_cnt, exp_cnt()); end
    end
  endtask

  task automatic test_halt();
    logic [15:0] old4;
    logic [31:0] cnt_h;
    rand_inputs();
    vld = 1'b1; hlt = 1'b1; rw = 1'b1; src = 2'b01; alu_d = 16'h0C0D; wreg = 3'd6;
    @(negedge clk);
    checks++;
    if (halted !== 1'b0) begin failures++; $display("FAIL halt_early got=%b exp=0", halted); end
    tick();
    set_bubble();
    ra1 = 3'd6;
    #1;
    checks++;
    if (halted !== 1'b1 || rd_data1 !== 16'h0C0D) begin
      failures++; $display("FAIL halt_set halted=%b r6=%h exp 1/0c0d", halted, rd_data1);
    end
    old4 = m_regs[4];
    cnt_h = exp_cnt();
    for (int n = 0; n < 3; n++) begin
      vld = 1'b1; rw = 1'b1; hlt = 1'($urandom); src = 2'b01; alu_d = 16'hBEEF; wreg = 3'd4; ra1 = 3'd4;
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b0 || rd_data1 !== old4) begin
        failures++; $display("FAIL halt_suppress en=%b r4=%h exp en=0 r4=%h", wb_en, rd_data1, old4);
      end
      tick();
    end
    set_bubble();
    #1;
    checks++;
    if (rd_data1 !== old4 || retire_cnt !== cnt_h || retire_cnt !== exp_cnt() || halted !== 1'b1) begin
      failures++; $display("FAIL halt_frozen r4=%h cnt=%h halted=%b exp r4=%h cnt=%h halted=1", rd_data1, retire_cnt, halted, old4, cnt_h);
    end
  endtask

  task automatic test_async_reset();
    set_bubble();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vld = 1'b1; rw = 1'b1; src = 2'b01; alu_d = 16'h7777; wreg = 3'd5; ra1 = 3'd5;
    tick();
    set_bubble();
    vld = 1'b1; hlt = 1'b1;
    tick();
    vld = 1'b1; rw = 1'b1; hlt = 1'b0; src = 2'b01; alu_d = 16'h1111; wreg = 3'd5;
    #1;
    checks++;
    if (rd_data1 !== 16'h7777 || halted !== 1'b1) begin
      failures++; $display("FAIL areset_pre r5=%h halted=%b exp 7777/1", rd_data1, halted);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rd_data1 !== 16'h0 || halted !== 1'b0 || retire_cnt !== 32'h0 || wb_en !== 1'b0) begin
      failures++; $display("FAIL areset_clear r5=%h halted=%b cnt=%h en=%b exp 0000/0/0/0", rd_data1, halted, retire_cnt, wb_en);
    end
    set_bubble();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_sources();
    test_bubble();
    test_random();
    test_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_regfile
